// File: rtl/sdp_fifo_ctrl.sv
// Synchronous FIFO controller around an external sdp_ram with a combinational read port (FWFT).
// Define FIFO_HWM_EN to enable the max_count high-water register; otherwise max_count is tied to 0.
module sdp_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_write,
  output logic [AW-1:0]         ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [AW-1:0]         ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           max_count
);

  function automatic bit is_pow2(int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sdp_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  localparam logic [AW:0] AF_W = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_W = AE_THRESH[AW:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        push, pop;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign almost_full  = (count >= AF_W);
  assign almost_empty = (count <= AE_W);

  assign wr_ready = rst_n & ~full;
  assign rd_valid = ~empty;
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  assign ram_write      = push & ~flush;
  assign ram_write_addr = wr_ptr_q[AW-1:0];
  assign ram_write_data = wr_data;
  assign ram_read_addr  = rd_ptr_q[AW-1:0];
  assign rd_data        = ram_read_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_HWM_EN
  logic [AW:0] max_q, max_d, cnt_d;

  // Tracks the occupancy the FIFO will have after this edge.
  assign cnt_d = wr_ptr_d - rd_ptr_d;

  always_comb begin
    max_d = max_q;
    if (flush)             max_d = '0;
    else if (cnt_d > max_q) max_d = cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= '0;
    else        max_q <= max_d;
  end

  assign max_count = max_q;
`else
  assign max_count = '0;
`endif

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Randomized + directed bench for sdp_fifo_ctrl with a queue-based reference model and
// a separate read-side monitor that pops expected words from a scoreboard queue.
module tb_sdp_fifo_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AFT   = 14;
  localparam int AET   = 2;

  logic          clk, rst_n, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data, ram_write_data, ram_read_data;
  logic          ram_write, full, empty, almost_full, almost_empty;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic [AW:0]   count, max_count;

  int checks   = 0;
  int failures = 0;

  // Model state: queue of words in flight plus slot positions and high-water mark.
  logic [DW-1:0] exp_q[$];
  int            wp = 0, rp = 0, hwm = 0;

  sdp_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_write(ram_write), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .max_count(max_count)
  );

  // Attached RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_write) mem[ram_write_addr] <= ram_write_data;
  assign ram_read_data = mem[ram_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Read-side monitor: whenever the DUT hands out a word, it must be the oldest expected one.
  always @(negedge clk) begin
    #2;
    if (rst_n && rd_valid && rd_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_underflow: got word 0x%0h expected none at %0t", rd_data, $time);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        chk("rd_data", int'(rd_data), int'(e));
      end
    end
  end

  task automatic check_status(input logic wv, input logic fl);
    automatic int  pre  = exp_q.size();
    automatic bit  wexp = rst_n && wv && (pre < DEPTH) && !fl;
    chk("count",        int'(count),        pre);
    chk("full",         int'(full),         int'(pre == DEPTH));
    chk("empty",        int'(empty),        int'(pre == 0));
    chk("almost_full",  int'(almost_full),  int'(pre >= AFT));
    chk("almost_empty", int'(almost_empty), int'(pre <= AET));
    chk("wr_ready",     int'(wr_ready),     int'(rst_n && pre < DEPTH));
    chk("rd_valid",     int'(rd_valid),     int'(pre > 0));
    chk("ram_write",    int'(ram_write),    int'(wexp));
    chk("ram_read_addr", int'(ram_read_addr), rp);
`ifdef FIFO_HWM_EN
    chk("max_count",    int'(max_count),    hwm);
`else
    chk("max_count",    int'(max_count),    0);
`endif
    if (wexp) begin
      chk("ram_write_addr", int'(ram_write_addr), wp);
      chk("ram_write_data", int'(ram_write_data), int'(wr_data));
    end
  endtask

  // One clock: called just after a falling edge, returns at the next falling edge.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    automatic int pre;
    automatic bit do_push, do_pop;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    pre = exp_q.size();
    check_status(wv, fl);
    #2;
    do_push = wv && (pre < DEPTH);
    do_pop  = rr && (pre > 0);
    if (fl) begin
      exp_q.delete();
      wp = 0; rp = 0; hwm = 0;
    end else begin
      if (do_pop) rp = (rp + 1) % DEPTH;
      if (do_push) begin
        exp_q.push_back(wd);
        wp = (wp + 1) % DEPTH;
      end
      if (pre + int'(do_push) - int'(do_pop) > hwm) hwm = pre + int'(do_push) - int'(do_pop);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle with a write attempt pending.
  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b1; rd_ready = 1'b1; flush = 1'b0;
    exp_q.delete();
    wp = 0; rp = 0; hwm = 0;
    #1;
    check_status(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    @(negedge clk);
    #1;
    check_status(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then an extra write attempt must be refused.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    // Drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Steady push+pop at occupancy 5 across the pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Single word into an empty FIFO, visible one cycle later.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 9 with push and pop requested.
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-burst at count 7.
    for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with phases biased toward filling or draining.
    for (int seg = 0; seg < 12; seg++) begin
      automatic int wprob = (seg % 2 == 0) ? 85 : 25;
      automatic int rprob = (seg % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 40; i++) begin
        automatic int r = $urandom_range(0, 299);
        if (r == 0) do_reset();
        else cycle($urandom_range(0, 99) < wprob, DW'($urandom),
                   $urandom_range(0, 99) < rprob, r < 5);
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
